// File: rtl/bundle_loop_sequencer.sv
// Back-pressured nested-loop scheduler for writeback bundles: fetches each bundle descriptor
// and walks (ib,ip,it,in,il,iwkw2) one beat per handshake. `LOOP_SEQ_PREFETCH_EN adds a shadow descriptor.
module bundle_loop_sequencer #(
    parameter  int WIDTH         = 32,
    parameter  int SRAM_RD_DEPTH = 8,
    localparam int BW            = $clog2(SRAM_RD_DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [BW-1:0]      n_bundles_1,
    output logic               desc_rd_en,
    output logic [BW-1:0]      desc_rd_addr,
    input  logic [5*WIDTH-1:0] desc_rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_ib,
    output logic [WIDTH-1:0]   m_ip,
    output logic [WIDTH-1:0]   m_it,
    output logic [WIDTH-1:0]   m_in,
    output logic [WIDTH-1:0]   m_il,
    output logic [WIDTH-1:0]   m_iwkw2,
    output logic               m_last,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_RUN, S_DONE} state_t;

    // Field order matches the descriptor word, MSB first.
    typedef struct packed {
        logic [WIDTH-1:0] wkw2;
        logic [WIDTH-1:0] l;
        logic [WIDTH-1:0] n;
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] p;
    } loop_t;

    state_t        state_q, state_d;
    logic [BW-1:0] ib_q, ib_d, nb_q, nb_d;
    loop_t         max_q, max_d, idx_q, idx_d, idx_nxt;
    logic          hs, inner_final, last_bundle;

`ifdef LOOP_SEQ_PREFETCH_EN
    loop_t shadow_q, shadow_d;
    logic  first_q, first_d, pf_pend_q, pf_pend_d;
`endif

    assign hs          = (state_q == S_RUN) && m_ready;
    assign inner_final = (idx_q == max_q);
    assign last_bundle = (ib_q == nb_q);

    // Innermost-first odometer; equality compare only so maxes are never exceeded.
    always_comb begin
        idx_nxt = idx_q;
        if (idx_q.wkw2 != max_q.wkw2) begin
            idx_nxt.wkw2 = idx_q.wkw2 + WIDTH'(1);
        end else begin
            idx_nxt.wkw2 = '0;
            if (idx_q.l != max_q.l) begin
                idx_nxt.l = idx_q.l + WIDTH'(1);
            end else begin
                idx_nxt.l = '0;
                if (idx_q.n != max_q.n) begin
                    idx_nxt.n = idx_q.n + WIDTH'(1);
                end else begin
                    idx_nxt.n = '0;
                    if (idx_q.t != max_q.t) begin
                        idx_nxt.t = idx_q.t + WIDTH'(1);
                    end else begin
                        idx_nxt.t = '0;
                        idx_nxt.p = (idx_q.p != max_q.p) ? idx_q.p + WIDTH'(1) : '0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ib_d         = ib_q;
        nb_d         = nb_q;
        max_d        = max_q;
        idx_d        = idx_q;
        desc_rd_en   = 1'b0;
        desc_rd_addr = '0;
`ifdef LOOP_SEQ_PREFETCH_EN
        shadow_d  = shadow_q;
        first_d   = first_q;
        pf_pend_d = pf_pend_q;
        if (pf_pend_q) begin
            shadow_d  = loop_t'(desc_rd_data);
            pf_pend_d = 1'b0;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    nb_d    = n_bundles_1;
                    ib_d    = '0;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                desc_rd_en   = 1'b1;
                desc_rd_addr = ib_q;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                max_d   = loop_t'(desc_rd_data);
                idx_d   = '0;
                state_d = S_RUN;
`ifdef LOOP_SEQ_PREFETCH_EN
                first_d   = 1'b1;
                pf_pend_d = 1'b0;
`endif
            end
            S_RUN: begin
                if (hs) begin
                    if (inner_final && last_bundle) begin
                        state_d = S_DONE;
                    end else if (inner_final) begin
                        ib_d  = ib_q + BW'(1);
                        idx_d = '0;
`ifdef LOOP_SEQ_PREFETCH_EN
                        if (first_q) begin
                            // Single-beat bundle: no earlier handshake to hide the read behind.
                            desc_rd_en   = 1'b1;
                            desc_rd_addr = ib_q + BW'(1);
                            state_d      = S_WAIT;
                        end else begin
                            // Read data may still be on the bus if it was issued last cycle.
                            max_d     = pf_pend_q ? loop_t'(desc_rd_data) : shadow_q;
                            first_d   = 1'b1;
                            pf_pend_d = 1'b0;
                        end
`else
                        state_d = S_FETCH;
`endif
                    end else begin
                        idx_d = idx_nxt;
`ifdef LOOP_SEQ_PREFETCH_EN
                        if (first_q) begin
                            first_d = 1'b0;
                            if (!last_bundle) begin
                                desc_rd_en   = 1'b1;
                                desc_rd_addr = ib_q + BW'(1);
                                pf_pend_d    = 1'b1;
                            end
                        end
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ib_q    <= '0;
            nb_q    <= '0;
            max_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ib_q    <= ib_d;
            nb_q    <= nb_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
        end
    end

`ifdef LOOP_SEQ_PREFETCH_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_q  <= '0;
            first_q   <= 1'b0;
            pf_pend_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            first_q   <= first_d;
            pf_pend_q <= pf_pend_d;
        end
    end
`endif

    assign m_valid = (state_q == S_RUN);
    assign m_last  = m_valid && inner_final && last_bundle;
    assign busy    = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign m_ib    = WIDTH'(ib_q);
    assign m_ip    = idx_q.p;
    assign m_it    = idx_q.t;
    assign m_in    = idx_q.n;
    assign m_il    = idx_q.l;
    assign m_iwkw2 = idx_q.wkw2;

endmodule

// File: tb/tb_bundle_loop_sequencer.sv
// Scoreboard bench for bundle_loop_sequencer: nested-loop model pushes expected beats at start,
// a negedge monitor pops/compares on handshakes and checks held values during stalls.
module tb_bundle_loop_sequencer;
    localparam int W = 32;
`ifdef LOOP_SEQ_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    logic           clk, rstn, start, m_ready;
    logic [2:0]     n_bundles_1;
    logic           desc_rd_en;
    logic [2:0]     desc_rd_addr;
    logic [5*W-1:0] desc_rd_data;
    logic           m_valid, m_last, busy, done;
    logic [W-1:0]   m_ib, m_ip, m_it, m_in, m_il, m_iwkw2;

    bundle_loop_sequencer #(.WIDTH(W), .SRAM_RD_DEPTH(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .n_bundles_1(n_bundles_1),
        .desc_rd_en(desc_rd_en), .desc_rd_addr(desc_rd_addr), .desc_rd_data(desc_rd_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_ib(m_ib), .m_ip(m_ip), .m_it(m_it), .m_in(m_in), .m_il(m_il), .m_iwkw2(m_iwkw2),
        .m_last(m_last), .busy(busy), .done(done)
    );

    logic [5*W-1:0] mem [8];
    logic [63:0]    sb [$];
    int             hs_q [$];
    int             addr_q [$];
    int             n_err = 0, n_chk = 0;
    int             cyc = 0, first_v_cyc = -1, last_hs_cyc = 0, done_cyc = 0, done_cnt = 0, start_cyc = 0;
    int             rdy_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk) if (desc_rd_en) desc_rd_data <= mem[desc_rd_addr];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [5*W-1:0] mk(input int wkw2, input int l, input int n, input int t, input int p);
        return {W'(wkw2), W'(l), W'(n), W'(t), W'(p)};
    endfunction

    function automatic logic [63:0] pk(input int ib, input int ip, input int it, input int n,
                                       input int il, input int iw, input bit last);
        logic [7:0] f [6];
        f[0] = 8'(ib); f[1] = 8'(ip); f[2] = 8'(it); f[3] = 8'(n); f[4] = 8'(il); f[5] = 8'(iw);
        return {f[0], f[1], f[2], f[3], f[4], f[5], 7'd0, last};
    endfunction

    // Reference: plain nested loops over the descriptors held in the bench SRAM.
    task automatic push_model(input int nb);
        int mw, ml, mn, mt, mp;
        for (int b = 0; b <= nb; b++) begin
            {mw, ml, mn, mt, mp} = mem[b];
            for (int ip = 0; ip <= mp; ip++)
                for (int it = 0; it <= mt; it++)
                    for (int n = 0; n <= mn; n++)
                        for (int il = 0; il <= ml; il++)
                            for (int iw = 0; iw <= mw; iw++)
                                sb.push_back(pk(b, ip, it, n, il, iw,
                                    (b == nb) && ip == mp && it == mt && n == mn && il == ml && iw == mw));
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            if (desc_rd_en) addr_q.push_back(int'(desc_rd_addr));
            if (m_valid) begin
                if (first_v_cyc < 0) first_v_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    chk(m_ready ? "beat" : "beat_stall",
                        pk(int'(m_ib), int'(m_ip), int'(m_it), int'(m_in), int'(m_il), int'(m_iwkw2), m_last),
                        sb[0]);
                    if (m_ready) begin
                        void'(sb.pop_front());
                        hs_q.push_back(cyc);
                        last_hs_cyc = cyc;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_test(input int nb, input int mode, input bit spam);
        int t, d0;
        push_model(nb);
        hs_q.delete();
        addr_q.delete();
        first_v_cyc = -1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rdy_mode    = mode;
        n_bundles_1 = 3'(nb);
        start       = 1'b1;
        start_cyc   = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            start = spam && (t % 7 == 3);
            if (spam && t == 4) n_bundles_1 = 3'd0;
        end
        start = 1'b0;
        if (t >= 3000) chk("timeout", 0, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("first_valid_lat", 64'(first_v_cyc - start_cyc), 3);
        chk("done_lat", 64'(done_cyc - last_hs_cyc), 1);
        chk("done_count", 64'(done_cnt - d0), 1);
        chk("sb_empty", 64'(sb.size()), 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int t;
        rstn = 1'b0; start = 1'b0; n_bundles_1 = '0; m_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        #12;
        chk("rst_outs", {m_valid, busy, done, desc_rd_en, m_last}, 0);
        chk("rst_idx", |{m_ib, m_ip, m_it, m_in, m_il, m_iwkw2, desc_rd_addr}, 0);
        rstn = 1'b1;

        // 1: wkw2=1,p=1 single bundle, always ready
        mem[0] = mk(1, 0, 0, 0, 1);
        run_test(0, 0, 1'b0);
        chk("t1_beats", 64'(hs_q.size()), 4);

        // 2: same with alternating ready
        run_test(0, 1, 1'b0);
        chk("t2_beats", 64'(hs_q.size()), 4);

        // 3: three all-zero bundles
        for (int i = 0; i < 8; i++) mem[i] = '0;
        run_test(2, 0, 1'b0);
        chk("t3_beats", 64'(hs_q.size()), 3);
        for (int i = 1; i < hs_q.size(); i++) chk("t3_gap", 64'(hs_q[i] - hs_q[i-1] - 1), 64'(GAP));
        chk("t3_addr_cnt", 64'(addr_q.size()), 3);
        for (int i = 0; i < addr_q.size(); i++) chk("t3_addr", 64'(addr_q[i]), 64'(i));

        // 4: two bundles with distinct maxes, random back-pressure
        mem[0] = mk(2, 1, 1, 0, 0);
        mem[1] = mk(0, 2, 0, 1, 1);
        run_test(1, 2, 1'b0);
        chk("t4_beats", 64'(hs_q.size()), 24);

        // 5: start spam and n_bundles_1 change mid-run
        mem[2] = mk(1, 0, 1, 0, 0);
        run_test(2, 2, 1'b1);
        chk("t5_beats", 64'(hs_q.size()), 28);

        // 6: abort mid-run, then restart
        mem[0] = mk(3, 3, 0, 0, 0);
        push_model(1);
        t = done_cnt;
        hs_q.delete();
        @(posedge clk);
        #1;
        rdy_mode = 0; n_bundles_1 = 3'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_idx", |{m_ib, m_ip, m_iwkw2, m_il}, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - t), 0);
        chk("abort_some_beats", 64'(hs_q.size() > 0), 1);
        mem[0] = mk(1, 0, 0, 0, 0);
        run_test(0, 0, 1'b0);
        chk("t6_addr0", 64'(addr_q.size() > 0 ? addr_q[0] : 99), 0);
        chk("t6_beats", 64'(hs_q.size()), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
